// File: rtl/bird_display_pkg.sv
// Shared constants and helpers for the animated bird sprite display.
// Default sprite geometry, screen size, colour key and the address-width helper.
package bird_display_pkg;

  localparam int DEF_SCREEN_WIDTH   = 640;
  localparam int DEF_SCREEN_HEIGHT  = 480;
  localparam int DEF_BIRD_LEFT_EDGE = 90;
  localparam int DEF_BIRD_WIDTH     = 35;
  localparam int DEF_BIRD_HEIGHT    = 35;
  localparam int DEF_BITS_PER_COLOR = 12;
  localparam int DEF_NUM_FRAMES     = 4;
  localparam int DEF_FRAME_HOLD     = 6;
  localparam logic [11:0] DEF_TRANSPARENT_COLOR = 12'h0F0;

  // Width needed to index 'depth' entries, never less than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Sprite artwork: a fixed arithmetic pattern over the linear ROM address.
  function automatic logic [31:0] sprite_word(input logic [31:0] addr);
    return addr * 32'd7 + 32'h123;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous single-port sprite ROM with a one-cycle registered read.
// Contents come from bird_display_pkg::sprite_word; addresses past DEPTH read as 0.
module sprite_rom
  import bird_display_pkg::*;
#(
  parameter int DEPTH = 4900,
  parameter int AW    = 13,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] addr_i,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] data_d, data_q;

  always_comb begin
    data_d = '0;
    if (32'(addr_i) < 32'(DEPTH)) begin
      data_d = DW'(sprite_word(32'(addr_i)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/animated_bird_display.sv
// Animated bird sprite overlay: two-stage pipeline from (x,y) to inside_bird/colorData.
// Define BIRD_TRANSPARENCY_EN to treat TRANSPARENT_COLOR ROM words as background.
module animated_bird_display
  import bird_display_pkg::*;
#(
  parameter int SCREEN_WIDTH   = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT  = DEF_SCREEN_HEIGHT,
  parameter int BIRD_LEFT_EDGE = DEF_BIRD_LEFT_EDGE,
  parameter int BIRD_WIDTH     = DEF_BIRD_WIDTH,
  parameter int BIRD_HEIGHT    = DEF_BIRD_HEIGHT,
  parameter int BITS_PER_COLOR = DEF_BITS_PER_COLOR,
  parameter int NUM_FRAMES     = DEF_NUM_FRAMES,
  parameter int FRAME_HOLD     = DEF_FRAME_HOLD,
  parameter logic [BITS_PER_COLOR-1:0] TRANSPARENT_COLOR = BITS_PER_COLOR'(DEF_TRANSPARENT_COLOR)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                frame_start,
  input  logic                                flap_en,
  input  logic [31:0]                         bird_reg,
  input  logic [9:0]                          x,
  input  logic [8:0]                          y,
  output logic                                inside_bird,
  output logic [BITS_PER_COLOR-1:0]           colorData,
  output logic [addr_width(NUM_FRAMES)-1:0]   frame_idx
);

  localparam int DEPTH = NUM_FRAMES * BIRD_WIDTH * BIRD_HEIGHT;
  localparam int AW    = addr_width(DEPTH);
  localparam int FW    = addr_width(NUM_FRAMES);
  localparam int HW    = addr_width(FRAME_HOLD);

  logic [8:0]    top_d, top_q;
  logic [HW-1:0] hold_d, hold_q;
  logic [FW-1:0] frame_d, frame_q;
  logic [AW-1:0] addr_d, addr_q;
  logic          box_d, box_q;
  logic          box2_q;
  logic [BITS_PER_COLOR-1:0] rom_data;
  logic          opaque;

  logic [10:0] x11, y11, top11;
  logic        in_x, in_y;
  logic [31:0] lin_addr;

  logic unused_bird_reg;
  assign unused_bird_reg = ^bird_reg[31:9];

  // Top edge and animation state only move on frame_start, so a frame never tears.
  always_comb begin
    top_d   = top_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    if (frame_start) begin
      top_d = bird_reg[8:0];
      if (flap_en) begin
        if (hold_q == HW'(FRAME_HOLD - 1)) begin
          hold_d  = '0;
          frame_d = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + FW'(1);
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
    end
  end

  always_comb begin
    x11      = {1'b0, x};
    y11      = {2'b00, y};
    top11    = {2'b00, top_q};
    in_x     = (x11 >= 11'(BIRD_LEFT_EDGE)) &&
               (x11 <= 11'(BIRD_LEFT_EDGE + BIRD_WIDTH - 1)) &&
               (x11 <  11'(SCREEN_WIDTH));
    in_y     = (y11 >= top11) &&
               (y11 <= top11 + 11'(BIRD_HEIGHT - 1)) &&
               (y11 <  11'(SCREEN_HEIGHT));
    box_d    = in_x && in_y;
    lin_addr = 32'(frame_q) * 32'(BIRD_WIDTH * BIRD_HEIGHT) +
               32'(y11 - top11) * 32'(BIRD_WIDTH) +
               32'(x11 - 11'(BIRD_LEFT_EDGE));
    addr_d   = box_d ? AW'(lin_addr) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_q   <= '0;
      hold_q  <= '0;
      frame_q <= '0;
      addr_q  <= '0;
      box_q   <= 1'b0;
      box2_q  <= 1'b0;
    end else begin
      top_q   <= top_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
      addr_q  <= addr_d;
      box_q   <= box_d;
      box2_q  <= box_q;
    end
  end

  sprite_rom #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (BITS_PER_COLOR)
  ) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .addr_i  (addr_q),
    .data_o  (rom_data)
  );

`ifdef BIRD_TRANSPARENCY_EN
  assign opaque = (rom_data != TRANSPARENT_COLOR);
`else
  logic unused_key;
  assign unused_key = ^TRANSPARENT_COLOR;
  assign opaque     = 1'b1;
`endif

  always_comb begin
    inside_bird = box2_q && opaque;
    colorData   = inside_bird ? rom_data : '0;
  end

  assign frame_idx = frame_q;

endmodule

// File: tb/tb_animated_bird_display.sv
// Directed self-checking bench for animated_bird_display (default parameters).
// Honours BIRD_TRANSPARENCY_EN when the same define is applied to the build.
module tb_animated_bird_display;

  logic        clk;
  logic        reset_n;
  logic        frame_start;
  logic        flap_en;
  logic [31:0] bird_reg;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        inside_bird;
  logic [11:0] colorData;
  logic [1:0]  frame_idx;

  int assertCount = 0;
  int failCount   = 0;

  animated_bird_display dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .flap_en     (flap_en),
    .bird_reg    (bird_reg),
    .x           (x),
    .y           (y),
    .inside_bird (inside_bird),
    .colorData   (colorData),
    .frame_idx   (frame_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference sprite artwork, written independently from its definition.
  function automatic logic [31:0] romModel(input int addr);
    return (32'(addr) * 32'd7 + 32'h123) & 32'hFFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pulseFrameStart();
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  // Present a pixel, wait the two pipeline cycles, then compare both outputs.
  task automatic applyStimulus(input string tag, input int px, input int py,
                               input logic expInside, input logic [31:0] expColor);
    x = 10'(px);
    y = 9'(py);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput({tag, "_inside"}, 32'(inside_bird), 32'(expInside));
    checkOutput({tag, "_color"}, 32'(colorData), expColor);
  endtask

  initial begin
    reset_n     = 1'b0;
    frame_start = 1'b0;
    flap_en     = 1'b0;
    bird_reg    = 32'd0;
    x           = 10'd0;
    y           = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_inside", 32'(inside_bird), 32'd0);
    checkOutput("rst_color", 32'(colorData), 32'd0);
    checkOutput("rst_frame", 32'(frame_idx), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    bird_reg = 32'd100;
    pulseFrameStart();
    applyStimulus("corner_tl", 90, 100, 1'b1, romModel(0));
    applyStimulus("right_out", 125, 110, 1'b0, 32'd0);
    applyStimulus("corner_br", 124, 134, 1'b1, romModel(1224));
    applyStimulus("left_out", 89, 100, 1'b0, 32'd0);
    applyStimulus("above_out", 90, 99, 1'b0, 32'd0);
    applyStimulus("below_out", 90, 135, 1'b0, 32'd0);
`ifdef BIRD_TRANSPARENCY_EN
    applyStimulus("key_pixel", 98, 133, 1'b0, 32'd0);
`else
    applyStimulus("key_pixel", 98, 133, 1'b1, 32'h0F0);
`endif

    bird_reg = 32'd200;
    applyStimulus("tear_old", 100, 100, 1'b1, romModel(10));
    applyStimulus("tear_new", 100, 200, 1'b0, 32'd0);
    pulseFrameStart();
    applyStimulus("moved_old", 100, 100, 1'b0, 32'd0);
    applyStimulus("moved_new", 100, 200, 1'b1, romModel(10));

    flap_en = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      pulseFrameStart();
      checkOutput($sformatf("flap_%0d", n), 32'(frame_idx), 32'((n / 6) % 4));
    end
    repeat (6) pulseFrameStart();
    checkOutput("frame1", 32'(frame_idx), 32'd1);
    applyStimulus("frame1_px", 90, 200, 1'b1, romModel(1225));

    flap_en = 1'b0;
    repeat (8) pulseFrameStart();
    checkOutput("frozen", 32'(frame_idx), 32'd1);

    bird_reg = 32'd460;
    pulseFrameStart();
    checkOutput("frozen_latch", 32'(frame_idx), 32'd1);
    applyStimulus("clip_first", 100, 460, 1'b1, romModel(1235));
    applyStimulus("clip_last", 100, 479, 1'b1, romModel(1900));
    applyStimulus("clip_480", 100, 480, 1'b0, 32'd0);
    applyStimulus("clip_494", 100, 494, 1'b0, 32'd0);

    applyStimulus("pre_reset", 100, 470, 1'b1, romModel(1225 + 10 * 35 + 10));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_inside", 32'(inside_bird), 32'd0);
    checkOutput("async_color", 32'(colorData), 32'd0);
    checkOutput("async_frame", 32'(frame_idx), 32'd0);
    x = 10'd90;
    y = 9'd0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_c1", 32'(inside_bird), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("post_rst_c2", 32'(inside_bird), 32'd1);
    checkOutput("post_rst_color", 32'(colorData), romModel(0));
    checkOutput("post_rst_frame", 32'(frame_idx), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
